decode_ctrl_stage: RTL and testbench

- Parametrised, registered successor to the combinational MIPS control decoder.
- Sits between the IF/ID latch and the EX stage of the pipelined CPU.
- Decodes the instruction word into control fields and performs load-use hazard detection against the instruction already in EX.
- Registers the decoded bundle into an ID/EX register with enable, flush and bubble insertion, and flags illegal encodings.

---
 rtl/decode_ctrl_stage_if.sv | 43 ++++
 rtl/decode_ctrl_stage.sv | 211 +++++++++++++++++++++
 tb/tb_decode_ctrl_stage.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/decode_ctrl_stage_if.sv
// ID-stage bus: IF/ID inputs, stall back-pressure and the registered ID/EX bundle.
// The master drives the instruction side; the slave is the decode stage.
interface decode_ctrl_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              instr_valid;
    logic [DATA_W-1:0] instr_i;
    logic [DATA_W-1:0] pcplus4_i;
    logic              en;
    logic              flush;
    logic              stall_o;
    logic              ex_valid;
    logic              ex_illegal;
    logic              ex_regwr;
    logic [1:0]        ex_alusrc;
    logic [1:0]        ex_regsel;
    logic [2:0]        ex_pcsrc;
    logic [REG_AW-1:0] ex_regdst;
    logic              ex_extop;
    logic              ex_dren;
    logic              ex_dwen;
    logic              ex_atomic;
    logic [3:0]        ex_aluop;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic [15:0]       ex_imm;
    logic [4:0]        ex_shamt;
    logic [DATA_W-1:0] ex_pcplus4;

    modport master (
        output instr_valid, instr_i, pcplus4_i, en, flush,
        input  stall_o, ex_valid, ex_illegal, ex_regwr, ex_alusrc, ex_regsel, ex_pcsrc,
               ex_regdst, ex_extop, ex_dren, ex_dwen, ex_atomic, ex_aluop, ex_rs, ex_rt,
               ex_imm, ex_shamt, ex_pcplus4
    );
    modport slave (
        input  instr_valid, instr_i, pcplus4_i, en, flush,
        output stall_o, ex_valid, ex_illegal, ex_regwr, ex_alusrc, ex_regsel, ex_pcsrc,
               ex_regdst, ex_extop, ex_dren, ex_dwen, ex_atomic, ex_aluop, ex_rs, ex_rt,
               ex_imm, ex_shamt, ex_pcplus4
    );
endinterface

// File: rtl/decode_ctrl_stage.sv
// MIPS control decode with load-use hazard detection, registered into an ID/EX
// register that supports hold, flush and bubble insertion.
module decode_ctrl_stage #(
    parameter int DATA_W    = 32,
    parameter int REG_AW    = 5,
    parameter int LINK_REG  = 31,
    parameter bit HAZARD_EN = 1'b1
) (
    input  logic                CLK,
    input  logic                nRST,
    decode_ctrl_stage_if.slave  bus
);
    localparam logic [3:0] ALU_SLL = 4'd0, ALU_SRL = 4'd1, ALU_ADD = 4'd2, ALU_SUB = 4'd3,
                           ALU_AND = 4'd4, ALU_OR  = 4'd5, ALU_XOR = 4'd6, ALU_NOR = 4'd7,
                           ALU_SLT = 4'd8, ALU_SLTU = 4'd9;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL   = 6'h03, OP_BEQ  = 6'h04, OP_BNE  = 6'h05,
        OP_ADDI  = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C,
        OP_ORI   = 6'h0D, OP_XORI = 6'h0E, OP_LUI   = 6'h0F, OP_LW   = 6'h23, OP_SW   = 6'h2B,
        OP_LL    = 6'h30, OP_SC   = 6'h38
    } opcode_t;

    typedef enum logic [5:0] {
        F_SLL = 6'h00, F_SRL = 6'h02, F_JR  = 6'h08, F_ADD = 6'h20, F_ADDU = 6'h21,
        F_SUB = 6'h22, F_SUBU = 6'h23, F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26,
        F_NOR = 6'h27, F_SLT = 6'h2A, F_SLTU = 6'h2B
    } funct_t;

    typedef struct packed {
        logic              illegal;
        logic              regwr;
        logic [1:0]        alusrc;
        logic [1:0]        regsel;
        logic [2:0]        pcsrc;
        logic [REG_AW-1:0] regdst;
        logic              extop;
        logic              dren;
        logic              dwen;
        logic              atomic;
        logic [3:0]        aluop;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [15:0]       imm;
        logic [4:0]        shamt;
        logic [DATA_W-1:0] pcplus4;
    } idex_t;

    logic [31:0] ins;
    logic [5:0]  op, fn;
    idex_t       dec, ex_d, ex_q;
    logic        vld_d, vld_q;
    logic        rs_use, rt_use, ill, stall;

    assign ins = bus.instr_i[31:0];
    assign op  = ins[31:26];
    assign fn  = ins[5:0];

    always_comb begin
        dec         = '0;
        rs_use      = 1'b0;
        rt_use      = 1'b0;
        ill         = 1'b0;
        dec.regdst  = REG_AW'(ins[15:11]);
        dec.aluop   = ALU_ADD;
        dec.rs      = REG_AW'(ins[25:21]);
        dec.rt      = REG_AW'(ins[20:16]);
        dec.imm     = ins[15:0];
        dec.shamt   = ins[10:6];
        dec.pcplus4 = bus.pcplus4_i;
        case (op)
            OP_RTYPE: begin
                dec.regwr = 1'b1;
                rs_use    = 1'b1;
                rt_use    = 1'b1;
                case (fn)
                    F_SLL:         begin dec.alusrc = 2'd2; dec.aluop = ALU_SLL; rs_use = 1'b0; end
                    F_SRL:         begin dec.alusrc = 2'd2; dec.aluop = ALU_SRL; rs_use = 1'b0; end
                    F_JR:          begin dec.regwr = 1'b0; dec.pcsrc = 3'd1; rt_use = 1'b0; end
                    F_ADD, F_ADDU: dec.aluop = ALU_ADD;
                    F_SUB, F_SUBU: dec.aluop = ALU_SUB;
                    F_AND:         dec.aluop = ALU_AND;
                    F_OR:          dec.aluop = ALU_OR;
                    F_XOR:         dec.aluop = ALU_XOR;
                    F_NOR:         dec.aluop = ALU_NOR;
                    F_SLT:         dec.aluop = ALU_SLT;
                    F_SLTU:        dec.aluop = ALU_SLTU;
                    default:       ill = 1'b1;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
                dec.regwr  = 1'b1;
                dec.regdst = REG_AW'(ins[20:16]);
                dec.alusrc = 2'd1;
                rs_use     = 1'b1;
                case (op)
                    OP_ADDI, OP_ADDIU: dec.extop = 1'b1;
                    OP_SLTI:           begin dec.extop = 1'b1; dec.aluop = ALU_SLT; end
                    OP_SLTIU:          begin dec.extop = 1'b1; dec.aluop = ALU_SLTU; end
                    OP_ANDI:           dec.aluop = ALU_AND;
                    OP_ORI:            dec.aluop = ALU_OR;
                    default:           dec.aluop = ALU_XOR;
                endcase
            end
            OP_LUI: begin
                dec.regwr  = 1'b1;
                dec.regsel = 2'd2;
                dec.regdst = REG_AW'(ins[20:16]);
            end
            OP_LW, OP_LL: begin
                dec.regwr  = 1'b1;
                dec.dren   = 1'b1;
                dec.regsel = 2'd3;
                dec.regdst = REG_AW'(ins[20:16]);
                dec.extop  = 1'b1;
                dec.alusrc = 2'd1;
                dec.atomic = (op == OP_LL);
                rs_use     = 1'b1;
            end
            OP_SW: begin
                dec.dwen   = 1'b1;
                dec.extop  = 1'b1;
                dec.alusrc = 2'd1;
                rs_use     = 1'b1;
                rt_use     = 1'b1;
            end
            // SC stores rt and then writes the success flag back into rt
            OP_SC: begin
                dec.dwen   = 1'b1;
                dec.regwr  = 1'b1;
                dec.regsel = 2'd3;
                dec.regdst = REG_AW'(ins[20:16]);
                dec.atomic = 1'b1;
                dec.extop  = 1'b1;
                dec.alusrc = 2'd1;
                rs_use     = 1'b1;
                rt_use     = 1'b1;
            end
            OP_J:   dec.pcsrc = 3'd2;
            OP_JAL: begin
                dec.pcsrc  = 3'd2;
                dec.regwr  = 1'b1;
                dec.regsel = 2'd1;
                dec.regdst = REG_AW'(LINK_REG);
            end
            OP_BEQ, OP_BNE: begin
                dec.aluop = ALU_SUB;
                dec.pcsrc = (op == OP_BEQ) ? 3'd3 : 3'd4;
                rs_use    = 1'b1;
                rt_use    = 1'b1;
            end
            default: ill = 1'b1;
        endcase
        if (ill) begin
            dec.illegal = 1'b1;
            dec.regwr   = 1'b0;
            dec.dren    = 1'b0;
            dec.dwen    = 1'b0;
            dec.pcsrc   = 3'd0;
            rs_use      = 1'b0;
            rt_use      = 1'b0;
        end
    end

    // Only a load in EX with a real destination can hazard against ID sources
    assign stall = HAZARD_EN && bus.instr_valid && vld_q && ex_q.dren && (ex_q.regdst != '0) &&
                   ((rs_use && (dec.rs == ex_q.regdst)) || (rt_use && (dec.rt == ex_q.regdst)));

    always_comb begin
        vld_d = vld_q;
        ex_d  = ex_q;
        if (bus.en) begin
            if (bus.flush || stall || !bus.instr_valid) begin
                vld_d = 1'b0;
                ex_d  = '0;
            end else begin
                vld_d = 1'b1;
                ex_d  = dec;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            vld_q <= 1'b0;
            ex_q  <= '0;
        end else begin
            vld_q <= vld_d;
            ex_q  <= ex_d;
        end
    end

    assign bus.stall_o    = stall;
    assign bus.ex_valid   = vld_q;
    assign bus.ex_illegal = ex_q.illegal;
    assign bus.ex_regwr   = ex_q.regwr;
    assign bus.ex_alusrc  = ex_q.alusrc;
    assign bus.ex_regsel  = ex_q.regsel;
    assign bus.ex_pcsrc   = ex_q.pcsrc;
    assign bus.ex_regdst  = ex_q.regdst;
    assign bus.ex_extop   = ex_q.extop;
    assign bus.ex_dren    = ex_q.dren;
    assign bus.ex_dwen    = ex_q.dwen;
    assign bus.ex_atomic  = ex_q.atomic;
    assign bus.ex_aluop   = ex_q.aluop;
    assign bus.ex_rs      = ex_q.rs;
    assign bus.ex_rt      = ex_q.rt;
    assign bus.ex_imm     = ex_q.imm;
    assign bus.ex_shamt   = ex_q.shamt;
    assign bus.ex_pcplus4 = ex_q.pcplus4;
endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Directed bench for decode_ctrl_stage: per-cycle expectations are queued by the
// stimulus and checked against the DUT on the falling edge by a monitor.
module tb_decode_ctrl_stage;
    localparam logic [3:0] A_SLL = 4'd0, A_ADD = 4'd2, A_SUB = 4'd3;

    typedef struct packed {
        logic        v, ill, wr;
        logic [1:0]  asrc, rsel;
        logic [2:0]  pcs;
        logic [4:0]  rd;
        logic        ext, dr, dw, at;
        logic [3:0]  aop;
        logic [4:0]  rs, rt;
        logic [15:0] imm;
        logic [4:0]  sh;
        logic [31:0] pc;
    } exp_t;

    typedef struct packed {
        logic st;
        exp_t ex;
    } rec_t;

    logic clk = 1'b0;
    logic nRST = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    rec_t sb_q[$];

    decode_ctrl_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();

    decode_ctrl_stage #(.DATA_W(32), .REG_AW(5), .LINK_REG(31), .HAZARD_EN(1'b1)) dut (
        .CLK(clk), .nRST(nRST), .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic v, ill, wr, input logic [1:0] asrc, rsel,
                                input logic [2:0] pcs, input logic [4:0] rd,
                                input logic ext, dr, dw, at, input logic [3:0] aop,
                                input logic [4:0] rs, rt, input logic [15:0] imm,
                                input logic [4:0] sh, input logic [31:0] pc);
        exp_t e;
        e = '{v, ill, wr, asrc, rsel, pcs, rd, ext, dr, dw, at, aop, rs, rt, imm, sh, pc};
        return e;
    endfunction

    // Hand-decoded expected bundles for the instruction words used below
    function automatic exp_t BUB();                        return '0; endfunction
    function automatic exp_t E_ADDI(input logic [31:0] p); return mk(1,0,1,1,0,0,5,1,0,0,0,A_ADD,6,5,16'hFFFC,31,p); endfunction
    function automatic exp_t E_LW2(input logic [31:0] p);  return mk(1,0,1,1,3,0,2,1,1,0,0,A_ADD,1,2,16'h0000,0,p); endfunction
    function automatic exp_t E_LW0(input logic [31:0] p);  return mk(1,0,1,1,3,0,0,1,1,0,0,A_ADD,1,0,16'h0000,0,p); endfunction
    function automatic exp_t E_ADD3(input logic [31:0] p); return mk(1,0,1,0,0,0,3,0,0,0,0,A_ADD,2,4,16'h1820,0,p); endfunction
    function automatic exp_t E_ADD0(input logic [31:0] p); return mk(1,0,1,0,0,0,3,0,0,0,0,A_ADD,0,4,16'h1820,0,p); endfunction
    function automatic exp_t E_SLL(input logic [31:0] p);  return mk(1,0,1,2,0,0,3,0,0,0,0,A_SLL,0,2,16'h1900,4,p); endfunction
    function automatic exp_t E_LUI(input logic [31:0] p);  return mk(1,0,1,0,2,0,2,0,0,0,0,A_ADD,2,2,16'h1234,8,p); endfunction
    function automatic exp_t E_ILL(input logic [31:0] p);  return mk(1,1,0,0,0,0,0,0,0,0,0,A_ADD,0,0,16'h0000,0,p); endfunction
    function automatic exp_t E_JAL(input logic [31:0] p);  return mk(1,0,1,0,1,2,31,0,0,0,0,A_ADD,0,0,16'h0010,0,p); endfunction
    function automatic exp_t E_BEQ(input logic [31:0] p);  return mk(1,0,0,0,0,3,0,0,0,0,0,A_SUB,1,2,16'h0003,0,p); endfunction
    function automatic exp_t E_BADF(input logic [31:0] p); return mk(1,1,0,0,0,0,7,0,0,0,0,A_ADD,0,0,16'h383F,0,p); endfunction
    function automatic exp_t E_SW(input logic [31:0] p);   return mk(1,0,0,1,0,0,0,1,0,1,0,A_ADD,1,2,16'h0008,0,p); endfunction

    localparam logic [31:0] I_ADDI = 32'h20C5FFFC, I_LW2 = 32'h8C220000, I_LW0 = 32'h8C200000,
                            I_ADD3 = 32'h00441820, I_ADD0 = 32'h00041820, I_SLL = 32'h00021900,
                            I_LUI  = 32'h3C421234, I_ILL = 32'hFC000000, I_JAL = 32'h0C000010,
                            I_BEQ  = 32'h10220003, I_BADF = 32'h0000383F, I_SW = 32'hAC220008;

    // One cycle: drive inputs, queue the outputs expected during this cycle
    task automatic cyc(input logic nr, iv, e, fl, input logic [31:0] ins, pc,
                       input logic st, input exp_t ex);
        rec_t r;
        @(posedge clk);
        #1;
        nRST            = nr;
        bus.instr_valid = iv;
        bus.en          = e;
        bus.flush       = fl;
        bus.instr_i     = ins;
        bus.pcplus4_i   = pc;
        r.st = st;
        r.ex = ex;
        sb_q.push_back(r);
    endtask

    always @(negedge clk) begin
        rec_t r;
        exp_t a;
        if (sb_q.size() > 0) begin
            r = sb_q.pop_front();
            a = '{bus.ex_valid, bus.ex_illegal, bus.ex_regwr, bus.ex_alusrc, bus.ex_regsel,
                  bus.ex_pcsrc, bus.ex_regdst, bus.ex_extop, bus.ex_dren, bus.ex_dwen,
                  bus.ex_atomic, bus.ex_aluop, bus.ex_rs, bus.ex_rt, bus.ex_imm, bus.ex_shamt,
                  bus.ex_pcplus4};
            n_chk++;
            if (bus.stall_o !== r.st) begin
                n_fail++;
                $display("FAIL stall_o @%0t: got %b expected %b", $time, bus.stall_o, r.st);
            end
            n_chk++;
            if (a !== r.ex) begin
                n_fail++;
                $display("FAIL idex_bundle @%0t: got %h expected %h", $time, a, r.ex);
            end
        end
    end

    initial begin
        bus.instr_valid = 1'b0;
        bus.en          = 1'b1;
        bus.flush       = 1'b0;
        bus.instr_i     = '0;
        bus.pcplus4_i   = '0;
        // reset and idle
        cyc(0, 0, 1, 0, 32'h0, 32'h0, 0, BUB());
        repeat (3) cyc(1, 0, 1, 0, 32'h0, 32'h0, 0, BUB());
        // ADDI, then load-use LW $2 / ADD $3,$2,$4
        cyc(1, 1, 1, 0, I_ADDI, 32'h104, 0, BUB());
        cyc(1, 1, 1, 0, I_LW2,  32'h108, 0, E_ADDI(32'h104));
        cyc(1, 1, 1, 0, I_ADD3, 32'h10C, 1, E_LW2(32'h108));
        cyc(1, 1, 1, 0, I_ADD3, 32'h10C, 0, BUB());
        cyc(1, 0, 1, 0, 32'h0,  32'h0,   0, E_ADD3(32'h10C));
        // LW $0 followed by a user of $0: no stall
        cyc(1, 1, 1, 0, I_LW0,  32'h110, 0, BUB());
        cyc(1, 1, 1, 0, I_ADD0, 32'h114, 0, E_LW0(32'h110));
        // LW $2 followed by SLL reading rt=$2: stall
        cyc(1, 1, 1, 0, I_LW2,  32'h118, 0, E_ADD0(32'h114));
        cyc(1, 1, 1, 0, I_SLL,  32'h11C, 1, E_LW2(32'h118));
        cyc(1, 1, 1, 0, I_SLL,  32'h11C, 0, BUB());
        // LW $2 followed by LUI (rs field = 2 but unused): no stall
        cyc(1, 1, 1, 0, I_LW2,  32'h120, 0, E_SLL(32'h11C));
        cyc(1, 1, 1, 0, I_LUI,  32'h124, 0, E_LW2(32'h120));
        // flush together with a stall condition
        cyc(1, 1, 1, 0, I_LW2,  32'h128, 0, E_LUI(32'h124));
        cyc(1, 1, 1, 1, I_ADD3, 32'h12C, 1, E_LW2(32'h128));
        cyc(1, 0, 1, 0, 32'h0,  32'h0,   0, BUB());
        // en=0 holds ID/EX for two cycles
        cyc(1, 1, 1, 0, I_ADDI, 32'h130, 0, BUB());
        cyc(1, 0, 0, 0, 32'h0,  32'h0,   0, E_ADDI(32'h130));
        cyc(1, 0, 0, 0, 32'h0,  32'h0,   0, E_ADDI(32'h130));
        cyc(1, 0, 1, 0, 32'h0,  32'h0,   0, E_ADDI(32'h130));
        cyc(1, 0, 1, 0, 32'h0,  32'h0,   0, BUB());
        // stall persists while en=0, then costs one bubble
        cyc(1, 1, 1, 0, I_LW2,  32'h140, 0, BUB());
        cyc(1, 1, 0, 0, I_ADD3, 32'h144, 1, E_LW2(32'h140));
        cyc(1, 1, 0, 0, I_ADD3, 32'h144, 1, E_LW2(32'h140));
        cyc(1, 1, 1, 0, I_ADD3, 32'h144, 1, E_LW2(32'h140));
        cyc(1, 1, 1, 0, I_ADD3, 32'h144, 0, BUB());
        cyc(1, 0, 1, 0, 32'h0,  32'h0,   0, E_ADD3(32'h144));
        // illegal opcode, JAL, BEQ, illegal funct, SW
        cyc(1, 1, 1, 0, I_ILL,  32'h150, 0, BUB());
        cyc(1, 1, 1, 0, I_JAL,  32'h154, 0, E_ILL(32'h150));
        cyc(1, 1, 1, 0, I_BEQ,  32'h158, 0, E_JAL(32'h154));
        cyc(1, 1, 1, 0, I_BADF, 32'h15C, 0, E_BEQ(32'h158));
        cyc(1, 1, 1, 0, I_SW,   32'h160, 0, E_BADF(32'h15C));
        // reset in the middle of a stall discards it
        cyc(1, 1, 1, 0, I_LW2,  32'h164, 0, E_SW(32'h160));
        cyc(1, 1, 1, 0, I_ADD3, 32'h168, 1, E_LW2(32'h164));
        cyc(0, 1, 1, 0, I_ADD3, 32'h168, 0, BUB());
        cyc(1, 0, 1, 0, 32'h0,  32'h0,   0, BUB());
        cyc(1, 0, 1, 0, 32'h0,  32'h0,   0, BUB());
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        n_chk++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
